rc4_encrypt: RTL

RC4_ENCRYPT -- requirements
Module: rc4_encrypt

---
 rtl/rc4_encrypt_pkg.sv | 29 ++
 rtl/rc4_encrypt_s_mem.sv | 24 ++
 rtl/rc4_encrypt.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_encrypt_pkg.sv
// Shared definitions for the RC4 encryptor: FSM states, sizes, key byte selection.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rc4_encrypt_pkg;

  localparam int KEY_BYTES = 3;
  localparam int SBOX_SIZE = 256;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    LEN,
    PRGA,
    DONE
  } state_t;

  // Picks key byte (idx mod 3); byte 0 sits in the top bits of the key word.
  function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [7:0] idx);
    logic [7:0] sel;
    sel = idx % 8'(KEY_BYTES);
    case (sel)
      8'd0:    key_byte = k[23:16];
      8'd1:    key_byte = k[15:8];
      default: key_byte = k[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rc4_encrypt_s_mem.sv
// 256x8 single-port synchronous RAM holding the RC4 permutation S.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; one access (read or write) per cycle.
module s_mem
  import rc4_encrypt_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       wren,
  output logic [7:0] rdata
);

  logic [7:0] mem [SBOX_SIZE];

  // Single port: write on wren, registered read of the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rc4_encrypt.sv
// RC4 encryptor: ct[0]=L, ct[k]=pt[k]^keystream for a 3-byte key, S kept in one single-port RAM.
// Latency: 256 INIT + 4*256 KSA + 2 LEN + 6*L PRGA + 1 DONE cycles from accept to rdy.
// Backpressure: en only accepted while rdy=1; requests while busy are ignored.
module rc4_encrypt
  import rc4_encrypt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  state_t      state, state_n;
  logic [2:0]  phase, phase_n;
  logic [7:0]  i, i_n;
  logic [7:0]  j, j_n;
  logic [23:0] key_q, key_n;
  logic [7:0]  len, len_n;
  logic [7:0]  si, si_n;
  logic [7:0]  sj, sj_n;
  logic [7:0]  ptb, ptb_n;

  logic [7:0]  s_addr;
  logic [7:0]  s_wdata;
  logic        s_wren;
  logic [7:0]  s_rdata;

  logic [7:0]  inc;
  logic [7:0]  jsum_ksa;
  logic [7:0]  jsum_prga;

  s_mem u_s_mem (
    .clk   (clk),
    .addr  (s_addr),
    .wdata (s_wdata),
    .wren  (s_wren),
    .rdata (s_rdata)
  );

  // State register: reset forces IDLE from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers: indices, latched key, length and swap/pad temporaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 3'd0;
      i     <= 8'd0;
      j     <= 8'd0;
      key_q <= 24'd0;
      len   <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      ptb   <= 8'd0;
    end else begin
      phase <= phase_n;
      i     <= i_n;
      j     <= j_n;
      key_q <= key_n;
      len   <= len_n;
      si    <= si_n;
      sj    <= sj_n;
      ptb   <= ptb_n;
    end
  end

  // Next-state and outputs. Each swap reads S[i] then S[j] before writing
  // either, so i==j writes the same value back twice and S stays intact.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    i_n       = i;
    j_n       = j;
    key_n     = key_q;
    len_n     = len;
    si_n      = si;
    sj_n      = sj;
    ptb_n     = ptb;
    s_addr    = 8'd0;
    s_wdata   = 8'd0;
    s_wren    = 1'b0;
    pt_addr   = 8'd0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    ct_wren   = 1'b0;
    rdy       = 1'b0;
    inc       = i + 8'd1;
    jsum_ksa  = j + s_rdata + key_byte(key_q, i);
    jsum_prga = j + s_rdata;

    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          key_n   = key;
          i_n     = 8'd0;
          j_n     = 8'd0;
          phase_n = 3'd0;
          state_n = INIT;
        end
      end

      INIT: begin
        s_addr  = i;
        s_wdata = i;
        s_wren  = 1'b1;
        i_n     = inc;
        if (i == 8'hFF) begin
          j_n     = 8'd0;
          phase_n = 3'd0;
          state_n = KSA;
        end
      end

      KSA: begin
        case (phase)
          3'd0: begin
            s_addr  = i;
            phase_n = 3'd1;
          end
          3'd1: begin
            si_n    = s_rdata;
            j_n     = jsum_ksa;
            s_addr  = jsum_ksa;
            phase_n = 3'd2;
          end
          3'd2: begin
            s_addr  = i;
            s_wdata = s_rdata;
            s_wren  = 1'b1;
            phase_n = 3'd3;
          end
          default: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
            i_n     = inc;
            phase_n = 3'd0;
            if (i == 8'hFF) begin
              state_n = LEN;
            end
          end
        endcase
      end

      LEN: begin
        if (phase == 3'd0) begin
          phase_n = 3'd1;
        end else begin
          ct_wren   = 1'b1;
          ct_wrdata = pt_rddata;
          len_n     = pt_rddata;
          i_n       = 8'd0;
          j_n       = 8'd0;
          phase_n   = 3'd0;
          state_n   = (pt_rddata == 8'd0) ? DONE : PRGA;
        end
      end

      PRGA: begin
        pt_addr = i;
        case (phase)
          3'd0: begin
            i_n     = inc;
            s_addr  = inc;
            pt_addr = inc;
            phase_n = 3'd1;
          end
          3'd1: begin
            ptb_n   = pt_rddata;
            si_n    = s_rdata;
            j_n     = jsum_prga;
            s_addr  = jsum_prga;
            phase_n = 3'd2;
          end
          3'd2: begin
            sj_n    = s_rdata;
            s_addr  = i;
            s_wdata = s_rdata;
            s_wren  = 1'b1;
            phase_n = 3'd3;
          end
          3'd3: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
            phase_n = 3'd4;
          end
          3'd4: begin
            s_addr  = si + sj;
            phase_n = 3'd5;
          end
          default: begin
            ct_wren   = 1'b1;
            ct_addr   = i;
            ct_wrdata = ptb ^ s_rdata;
            phase_n   = 3'd0;
            if (i == len) begin
              state_n = DONE;
            end
          end
        endcase
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
